// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery-domain conversion block.
package mont_pkg;

  localparam int MONT_DWIDTH = 32;

  typedef enum logic {TO_MONT, FROM_MONT} mont_dir_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mont_state_e;

endpackage

// File: rtl/mont_step.sv
// One bit-serial iteration: doubling-with-reduce toward the Montgomery domain,
// or halving modulo q (add q when odd) back out of it.
module mont_step
  import mont_pkg::*;
#(
  parameter int DWIDTH = MONT_DWIDTH
) (
  input  mont_dir_e           dir,
  input  logic [DWIDTH:0]     r,
  input  logic [DWIDTH-1:0]   q,
  output logic [DWIDTH:0]     r_next
);

  logic [DWIDTH:0] q_ext;
  logic [DWIDTH:0] t;

  assign q_ext = {1'b0, q};

  // With r < q < 2^DWIDTH, both 2r and r+q fit in DWIDTH+1 bits.
  always_comb begin
    t      = '0;
    r_next = r;
    if (dir == TO_MONT) begin
      t      = {r[DWIDTH-1:0], 1'b0};
      r_next = (t >= q_ext) ? (t - q_ext) : t;
    end else begin
      t      = r[0] ? (r + q_ext) : r;
      r_next = {1'b0, t[DWIDTH:1]};
    end
  end

endmodule

// File: rtl/mont_convert.sv
// Iterative normal <-> Montgomery domain converter (R = 2^DWIDTH), one
// shift/conditional add-subtract per cycle, valid/ready on both sides.
module mont_convert
  import mont_pkg::*;
#(
  parameter int DWIDTH = MONT_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dir,
  input  logic [DWIDTH-1:0] in_q,
  input  logic [DWIDTH-1:0] in_a,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_err
);

  localparam int CNT_W = $clog2(DWIDTH) + 1;

  mont_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  mont_dir_e         dir_r;
  logic [DWIDTH-1:0] q_r;
  logic [DWIDTH:0]   r;
  logic [DWIDTH:0]   r_next;
  logic              accept;
  logic              bad_req;
  logic              last_step;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign bad_req   = !in_q[0] || (in_q < DWIDTH'(3)) || (in_a >= in_q);
  assign last_step = (cnt == CNT_W'(DWIDTH - 1));

  mont_step #(.DWIDTH(DWIDTH)) u_step (
    .dir    (dir_r),
    .r      (r),
    .q      (q_r),
    .r_next (r_next)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_req ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers; rejected requests finish with a zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= '0;
            out_data <= '0;
            out_err  <= bad_req;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            out_data <= r_next[DWIDTH-1:0];
            out_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture and the running residue; meaningful only while RUN.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      dir_r <= mont_dir_e'(in_dir);
      q_r   <= in_q;
      r     <= {1'b0, in_a};
    end else if (state == RUN) begin
      r <= r_next;
    end
  end

endmodule
